// File: rtl/mem_bus_master_if.sv
// Signal bundle between mem_bus_master, its control unit and the attached RAM.
// Handshakes: req is sampled only while busy=0 and each accepted req ends with a one-cycle done
// (err qualifies it). MOV rises after one setup cycle and stays high until MOC=1, then the master
// drops MOV and waits for MOC=0.
interface mem_bus_master_if;
  logic        req;
  logic        rd;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        MOV;
  logic        RW;
  logic [1:0]  typeData;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        MOC;
  logic [2:0]  state_dbg;

  modport master (
    input  req, rd, size, sgn, addr, wdata, mem_rdata, MOC,
    output busy, done, err, rdata, MOV, RW, typeData, mem_addr, mem_wdata, state_dbg
  );

  modport slave (
    output req, rd, size, sgn, addr, wdata, mem_rdata, MOC,
    input  busy, done, err, rdata, MOV, RW, typeData, mem_addr, mem_wdata, state_dbg
  );
endinterface

// File: rtl/mem_bus_master.sv
// Single-access memory bus master: checks alignment/range, runs the MOV/MOC handshake
// with a timeout, and sign/zero-extends load data.
module mem_bus_master #(
  parameter int TIMEOUT   = 16,
  parameter int MEM_BYTES = 256
) (
  input logic              CLK,
  input logic              CLR,
  mem_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t         state_q;
  logic           rd_q;
  logic [1:0]     size_q;
  logic           sgn_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [CW-1:0]  cnt_q;
  logic           done_q;
  logic           err_q;
  logic [31:0]    rdata_q;
  logic           mov_q;
  logic           rw_q;
  logic [1:0]     type_q;
  logic [31:0]    maddr_q;
  logic [31:0]    mwdata_q;

  logic [32:0]    nbytes;
  logic [32:0]    end_addr;
  logic           reject;
  logic [31:0]    rdata_ext;

  // The end address is formed in 33 bits so addresses near 2^32 cannot wrap past the range check.
  always_comb begin
    nbytes = 33'd4;
    case (size_q)
      2'b00:   nbytes = 33'd1;
      2'b01:   nbytes = 33'd2;
      default: nbytes = 33'd4;
    endcase
    end_addr = {1'b0, addr_q} + nbytes;
    reject   = (size_q == 2'b11)
            || (size_q == 2'b01 && addr_q[0])
            || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
            || (end_addr > 33'(MEM_BYTES));
  end

  always_comb begin
    rdata_ext = bus.mem_rdata;
    case (size_q)
      2'b00:   rdata_ext = {{24{sgn_q & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      2'b01:   rdata_ext = {{16{sgn_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      default: rdata_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      rd_q     <= 1'b0;
      size_q   <= 2'b00;
      sgn_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      mov_q    <= 1'b0;
      rw_q     <= 1'b1;
      type_q   <= 2'b00;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            rd_q    <= bus.rd;
            size_q  <= bus.size;
            sgn_q   <= bus.sgn;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (reject) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            maddr_q  <= addr_q;
            rw_q     <= rd_q;
            type_q   <= size_q;
            mwdata_q <= wdata_q;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mov_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.MOC) begin
            mov_q   <= 1'b0;
            cnt_q   <= '0;
            if (rd_q) rdata_q <= rdata_ext;
            state_q <= S_RELEASE;
          end else if (cnt_q == CNT_LAST) begin
            mov_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          if (!bus.MOC) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.MOV       = mov_q;
  assign bus.RW        = rw_q;
  assign bus.typeData  = type_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The parameter TIMEOUT SHALL default to 16 and SHALL set the maximum number of cycles spent waiting for MOC, or for MOC to release, before the access is aborted.
REQ-002 The parameter MEM_BYTES SHALL default to 256 and SHALL be the number of addressable bytes in the attached memory.
REQ-003 Port CLK SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port CLR SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port req SHALL be an input, 1 bit: the control unit requests an access; it is sampled only in IDLE.
REQ-006 Port rd SHALL be an input, 1 bit: 1 means read, 0 means write.
REQ-007 Port size SHALL be an input, 2 bits: 00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 Port sgn SHALL be an input, 1 bit: 1 means sign-extend byte and halfword reads, 0 means zero-extend.
REQ-009 Port addr SHALL be an input, 32 bits: byte address.
REQ-010 Port wdata SHALL be an input, 32 bits: store data, right-justified.
REQ-011 Port busy SHALL be an output, 1 bit: high whenever the block is not in IDLE.
REQ-012 Port done SHALL be an output, 1 bit: one-cycle pulse that ends every accepted request.
REQ-013 Port err SHALL be an output, 1 bit: valid only while done=1; 1 means the access failed.
REQ-014 Port rdata SHALL be an output, 32 bits: extended load data, held until the next done pulse.
REQ-015 Port MOV SHALL be an output, 1 bit: memory operation valid, driven to the RAM.
REQ-016 Port RW SHALL be an output, 1 bit: RAM direction, 1 read and 0 write.
REQ-017 Port typeData SHALL be an output, 2 bits: RAM access width, same encoding as size.
REQ-018 Port mem_addr SHALL be an output, 32 bits: address to the RAM.
REQ-019 Port mem_wdata SHALL be an output, 32 bits: store data to the RAM.
REQ-020 Port mem_rdata SHALL be an input, 32 bits: read data from the RAM, right-justified.
REQ-021 Port MOC SHALL be an input, 1 bit: memory operation complete, from the RAM.

Function
REQ-022 The block SHALL have states IDLE, CHECK, ISSUE, WAIT, RELEASE and DONE.
REQ-023 In IDLE with req=1, the block SHALL register rd, size, sgn, addr and wdata and go to CHECK.
REQ-024 In CHECK, the request SHALL be rejected when size=11, when a halfword has addr[0]=1, when a word has addr[1:0]!=00, or when addr+bytes exceeds MEM_BYTES.
- A rejected request SHALL go to DONE with err=1 and no MOV assertion.
- An accepted request SHALL go to ISSUE.
REQ-025 In ISSUE, mem_addr, RW, typeData and mem_wdata SHALL be driven from the registered request, and MOV SHALL be set to 1 at the next edge (setup of at least one cycle before MOV).
REQ-026 In WAIT, MOV SHALL be held at 1 and all bus outputs held stable until MOC=1 is sampled.
- Then, for a read, mem_rdata SHALL be captured and the block SHALL go to RELEASE with MOV set to 0.
REQ-027 In RELEASE, the block SHALL wait for MOC=0, then go to DONE.
REQ-028 A cycle counter SHALL count cycles in WAIT and in RELEASE, clearing on each state entry.
- When the count reaches TIMEOUT, the block SHALL drop MOV and go to DONE with err=1.
- rdata SHALL be left unchanged on a timeout.
REQ-029 In DONE, done SHALL be 1 for exactly one cycle and the block SHALL then return to IDLE.
- A req seen in DONE SHALL be ignored; a new request needs req=1 in IDLE.
REQ-030 Read extension: byte reads SHALL place bits [7:0] into rdata, filling the upper 24 bits with bit 7 when sgn=1 and with zeros otherwise.
- Halfword reads SHALL do the same with bits [15:0] and bit 15.
- Word reads SHALL pass through unchanged.
REQ-031 A write that completes SHALL leave rdata unchanged.
REQ-032 MOC=1 seen in IDLE, CHECK or ISSUE SHALL be ignored.

Reset
REQ-033 While CLR=1, the block SHALL force state IDLE and drive MOV=0, RW=1, typeData=00, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, rdata=0 and counter=0, without waiting for a clock edge.
REQ-034 CLR during an access SHALL drop MOV at once and produce no done pulse.
REQ-035 After CLR falls, the first req SHALL be accepted on the next rising edge.

Verification
REQ-036 The bench SHALL cover: word read at addr 8 with memory word 0xDEADBEEF and MOC after 3 cycles -> rdata=0xDEADBEEF, err=0, one done pulse, MOV high for exactly the WAIT cycles.
REQ-037 The bench SHALL cover: byte read at addr 5 with sgn=1 and mem_rdata=0x00000080 -> rdata=0xFFFFFF80; repeated with sgn=0 -> rdata=0x00000080.
REQ-038 The bench SHALL cover: halfword write at addr 3 -> done with err=1, MOV never asserted.
REQ-039 The bench SHALL cover: word write at addr 252 of 0x12345678 -> RW=0, typeData=10, mem_wdata=0x12345678 while MOV=1; then addr 254 word -> err=1.
REQ-040 The bench SHALL cover: read with MOC never asserted -> after 16 WAIT cycles MOV=0, done=1, err=1, rdata unchanged.
REQ-041 The bench SHALL cover: CLR pulsed in the middle of WAIT -> MOV=0 immediately, busy=0, no done pulse; the next read completes normally.
